// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared constants and the state type for the register
// file dump reader.
//   NUM_REGS_DEF / DATA_W_DEF / ADDR_W_DEF : default geometry (32 x 64-bit, 5-bit index)
//   dump_state_t                            : IDLE, FETCH, PRESENT, DONE
package regfile_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_idx_ctr.sv
// regfile_dump_idx_ctr: loadable index counter that wraps NUM_REGS-1 -> 0 and
// flags when it has reached the latched final index.
// Ports:
//   clk, reset (async, active-low)
//   load      : latch load_val as the current index and load_last as the final index
//   load_val  : first index of the range (reduced modulo NUM_REGS)
//   load_last : final index of the range (reduced modulo NUM_REGS)
//   inc       : advance the current index by one, wrapping
//   cur       : current index
//   is_last   : cur equals the latched final index
module regfile_dump_idx_ctr
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] load_last,
  input  logic              inc,
  output logic [ADDR_W-1:0] cur,
  output logic              is_last
);

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;

  // Indices outside the file map back into it so the walk always terminates.
  function automatic logic [ADDR_W-1:0] reduce_idx(input logic [ADDR_W-1:0] v);
    reduce_idx = ADDR_W'(32'(v) % NUM_REGS);
  endfunction

  always_comb begin
    cur_d  = cur_q;
    last_d = last_q;
    if (load) begin
      cur_d  = reduce_idx(load_val);
      last_d = reduce_idx(load_last);
    end else if (inc) begin
      cur_d = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q  <= '0;
      last_q <= '0;
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
    end
  end

  assign cur     = cur_q;
  assign is_last = (cur_q == last_q);

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks a programmed range of register indices, reads each one
// from the register file and streams (index, value) beats over valid/ready.
// Optional build macro: REGFILE_DUMP_SKIP_ZERO_EN -- registers reading as zero
// are skipped without producing a beat.
// Ports:
//   clk, reset (async, active-low)
//   start, first_reg, last_reg : dump request, range sampled only in IDLE
//   rd_addr / rd_data          : combinational read port of the register file
//   out_valid / out_ready      : beat handshake; out_addr / out_data carry the beat
//   busy                       : any state other than IDLE
//   done                       : one-cycle pulse after the final beat is taken
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] cur;
  logic              is_last;
  logic              ctr_load, ctr_inc;
  logic              skip_zero;

  regfile_dump_idx_ctr #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_idx_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .load_val  (first_reg),
    .load_last (last_reg),
    .inc       (ctr_inc),
    .cur       (cur),
    .is_last   (is_last)
  );

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  assign skip_zero = (rd_data == '0);
`else
  assign skip_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ctr_load = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (skip_zero) begin
          // Zero register: no beat, move straight on to the next index.
          if (is_last) state_d = DONE;
          else         ctr_inc = 1'b1;
        end else begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            ctr_inc = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == PRESENT);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // Read address follows cur only while fetching and otherwise keeps the
  // last address driven; the beat is captured on the fetch edge.
  always_comb begin
    rd_addr_d  = (state_q == FETCH) ? cur : rd_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    if (state_q == FETCH && !skip_zero) begin
      out_addr_d = cur;
      out_data_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign rd_addr  = rd_addr_d;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized self-checking bench for regfile_dump. A register
// file array answers rd_addr combinationally; a reference model derives the
// expected beat list and timing from the range rules.
module tb_regfile_dump;

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [4:0]  first_reg, last_reg, rd_addr, out_addr;
  logic [63:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic [63:0] regs [NREGS];
  assign rd_data = regs[rd_addr];

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  int          q_addr[$];
  logic [63:0] q_data[$];
  int          q_cyc[$];
  int          exp_addr[$];
  logic [63:0] exp_data[$];
  int          exp_cyc[$];
  int          exp_done_cyc;
  int          start_cyc;
  int          done_cnt, unstable, done_cyc;
  bit          timed_out;
  logic        busy_after, done_after;

  // Reference: walk first..last modulo NREGS. A presented register costs a
  // fetch cycle plus a present cycle (beat visible in the second); a skipped
  // one costs only the fetch cycle. Done follows the last register.
  function automatic void build_expect(input int first, input int last, input int t0);
    int i = first % NREGS;
    int t = t0 + 1;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    while (1) begin
      if (!SKIP || regs[i] != 64'd0) begin
        exp_addr.push_back(i); exp_data.push_back(regs[i]); exp_cyc.push_back(t + 1);
        t += 2;
      end else begin
        t += 1;
      end
      if (i == last % NREGS) break;
      i = (i + 1) % NREGS;
    end
    exp_done_cyc = t;
  endfunction

  task automatic kick(input int f, input int l);
    @(negedge clk);
    first_reg = f[4:0]; last_reg = l[4:0]; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumer: stalls each beat for 'stall' cycles, records accepted beats,
  // done pulses and any change of the beat while stalled. Optionally pulses
  // start (range 7..7) once 'inject' beats have been taken.
  task automatic collect(input int stall, input int budget, input int inject);
    int w = 0;
    bit held = 0, post = 0, injected = 0;
    int ha = 0;
    logic [63:0] hd = '0;
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    done_cnt = 0; unstable = 0; timed_out = 1; done_cyc = -1;
    busy_after = 1'b1; done_after = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (post) begin
        busy_after = busy; done_after = done; timed_out = 0;
        break;
      end
      if (done) begin done_cnt++; done_cyc = cyc; post = 1; end
      start = 1'b0;
      if (inject >= 0 && !injected && q_addr.size() == inject) begin
        start = 1'b1; first_reg = 5'd7; last_reg = 5'd7; injected = 1;
      end
      if (out_valid) begin
        if (held && (int'(out_addr) != ha || out_data !== hd)) unstable++;
        if (w < stall) begin
          if (!held) begin ha = int'(out_addr); hd = out_data; held = 1; end
          out_ready = 1'b0; w++;
        end else begin
          out_ready = 1'b1;
          q_addr.push_back(int'(out_addr)); q_data.push_back(out_data); q_cyc.push_back(cyc);
          w = 0; held = 0;
        end
      end else begin
        out_ready = (stall == 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    n_chk++; if (out_addr !== 5'd0) begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    n_chk++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < NREGS; i++) regs[i] = 64'(i * 17);
    out_ready = 1'b1;
    kick(0, 31);
    build_expect(0, 31, start_cyc);
    collect(0, 200, -1);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL full_timeout: got no done want done"); end
    n_chk++; if (q_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL full_count: got %0d want %0d", q_addr.size(), exp_addr.size()); end
    for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
      n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL full_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
      n_chk++; if (q_cyc[j] != exp_cyc[j]) begin n_fail++; $display("FAIL full_cycle%0d: got %0d want %0d", j, q_cyc[j], exp_cyc[j]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    n_chk++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, exp_done_cyc); end
    n_chk++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL full_done_width: got %b want 0", done_after); end
    n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    kick(3, 5);
    build_expect(3, 5, start_cyc);
    collect(4, 200, -1);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got no done want done"); end
    n_chk++; if (q_addr.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", q_addr.size()); end
    for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
      n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL bp_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
    end
    n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    if (q_cyc.size() >= 2) begin
      n_chk++; if (q_cyc[1] - q_cyc[0] != 6) begin n_fail++; $display("FAIL bp_spacing: got %0d want 6", q_cyc[1] - q_cyc[0]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    int wr [4] = '{30, 31, 0, 1};
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    kick(30, 1);
    collect(0, 200, -1);
    n_chk++; if (q_addr.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", q_addr.size()); end
    for (int j = 0; j < q_addr.size() && j < 4; j++) begin
      n_chk++; if (q_addr[j] != wr[j] || q_data[j] !== regs[wr[j]]) begin n_fail++; $display("FAIL wrap_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], wr[j], regs[wr[j]]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int extra = 0;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    kick(10, 14);
    build_expect(10, 14, start_cyc);
    collect(1, 200, 1);
    n_chk++; if (q_addr.size() != 5) begin n_fail++; $display("FAIL ign_count: got %0d want 5", q_addr.size()); end
    for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
      n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL ign_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    for (int n = 0; n < 6; n++) begin
      if (out_valid || busy || done) extra++;
      @(negedge clk);
    end
    n_chk++; if (extra != 0) begin n_fail++; $display("FAIL ign_second_dump: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_zero_regs();
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    regs[2] = 64'd0; regs[3] = 64'hDEAD; regs[4] = 64'd0;
    kick(2, 4);
    build_expect(2, 4, start_cyc);
    collect(0, 100, -1);
    n_chk++; if (q_addr.size() != (SKIP ? 1 : 3)) begin n_fail++; $display("FAIL zero_count: got %0d want %0d", q_addr.size(), SKIP ? 1 : 3); end
    for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
      n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL zero_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    for (int i = 20; i <= 23; i++) regs[i] = 64'd0;
    kick(20, 23);
    build_expect(20, 23, start_cyc);
    collect(0, 100, -1);
    n_chk++; if (q_addr.size() != (SKIP ? 0 : 4)) begin n_fail++; $display("FAIL allzero_count: got %0d want %0d", q_addr.size(), SKIP ? 0 : 4); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL allzero_done_count: got %0d want 1", done_cnt); end
    n_chk++; if (done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL allzero_done_cycle: got %0d want %0d", done_cyc, exp_done_cyc); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int f = $urandom_range(0, NREGS - 1);
      int l = $urandom_range(0, NREGS - 1);
      int st = $urandom_range(0, 2);
      for (int i = 0; i < NREGS; i++) regs[i] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      kick(f, l);
      build_expect(f, l, start_cyc);
      collect(st, 400, -1);
      n_chk++; if (timed_out || q_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d (timeout %0d) want %0d", it, q_addr.size(), timed_out, exp_addr.size()); end
      for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
        n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL rand%0d_beat%0d: got (%0d,%h) want (%0d,%h)", it, j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
        if (st == 0) begin
          n_chk++; if (q_cyc[j] != exp_cyc[j]) begin n_fail++; $display("FAIL rand%0d_cycle%0d: got %0d want %0d", it, j, q_cyc[j], exp_cyc[j]); end
        end
      end
      n_chk++; if (done_cnt != 1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_done: got count %0d busy %b want 1 and 0", it, done_cnt, busy_after); end
      n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d want 0", it, unstable); end
    end
  endtask

  task automatic test_mid_reset();
    bit seen = 0;
    int extra = 0;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    out_ready = 1'b0;
    kick(9, 20);
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL mid_present: got no valid want valid"); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got valid %b busy %b done %b want 0 0 0", out_valid, busy, done); end
    n_chk++; if (out_addr !== 5'd0 || out_data !== 64'd0 || rd_addr !== 5'd0) begin n_fail++; $display("FAIL mid_reset_data: got addr %0d data %h rd %0d want 0 0 0", out_addr, out_data, rd_addr); end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (out_valid || busy || done) extra++;
      @(negedge clk);
    end
    n_chk++; if (extra != 0) begin n_fail++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", extra); end
    kick(5, 6);
    build_expect(5, 6, start_cyc);
    collect(0, 100, -1);
    n_chk++; if (q_addr.size() != 2) begin n_fail++; $display("FAIL after_reset_count: got %0d want 2", q_addr.size()); end
    for (int j = 0; j < q_addr.size() && j < exp_addr.size(); j++) begin
      n_chk++; if (q_addr[j] != exp_addr[j] || q_data[j] !== exp_data[j]) begin n_fail++; $display("FAIL after_reset_beat%0d: got (%0d,%h) want (%0d,%h)", j, q_addr[j], q_data[j], exp_addr[j], exp_data[j]); end
    end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL after_reset_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    first_reg = '0; last_reg = '0;
    for (int i = 0; i < NREGS; i++) regs[i] = 64'(i * 17);
    test_reset();
    test_full_range();
    test_back_pressure();
    test_wrap();
    test_start_ignored();
    test_zero_regs();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
